scc_access_ctl: RTL and testbench
=================================

// Module: scc_access_ctl
// PURPOSE
//  Sequencer/arbiter in front of the Z8530 SCC. Converts single-cycle register
//  requests from the CPU bus interface into Z8530 bus cycles: WR0 pointer write,
//  then the data phase, with timed CE_n/RD_n/WR_n strobes and enforced recovery.
//  Also runs an init table (chan/reg/value from external ROM) at boot; init has
//  priority over the CPU port.
// PARAMETERS
//  STROBE_CYCLES    4  clk cycles RD_n/WR_n held low (>=1)
//  RECOVERY_CYCLES  6  min idle clks between end of one SCC cycle and next CE_n (>=1)
//  INIT_LEN         8  number of init table entries (1..256)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  cpu_req      in   1   level; held with cpu_* stable until cpu_ack
//  cpu_we       in   1   1=write, 0=read
//  cpu_data     in   1   1=data port (DC_n=1, single access); 0=control reg
//  cpu_chan     in   1   0=channel A, 1=channel B
//  cpu_reg      in   4   control register number (ignored if cpu_data)
//  cpu_wdata    in   8   write data
//  cpu_rdata    out  8   read data, valid with cpu_ack, held until next read
//  cpu_ack      out  1   one-cycle completion pulse
//  init_start   in   1   pulse: run init table
//  init_busy    out  1   high from accept of init_start to last entry's hold cycle
//  init_addr    out  8   table index 0..INIT_LEN-1
//  init_entry   in   13  [12]=chan(1=B) [11:8]=reg [7:0]=value; valid 1 clk after init_addr
//  scc_ce_n, scc_rd_n, scc_wr_n  out 1  Z8530 strobes
//  scc_ab_n     out  1   1=channel A, 0=channel B
//  scc_dc_n     out  1   0=control, 1=data
//  scc_d_out    out  8   write data;  scc_d_oe out 1 drive enable;  scc_d_in in 8
// BEHAVIOUR
//  Reset (async): ce_n/rd_n/wr_n=1, ab_n=1, dc_n=0, d_oe=0, d_out=0, cpu_ack=0,
//   cpu_rdata=0, init_busy=0, init_addr=0, recovery counter=0, FSM=IDLE, no pending init.
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> (PTR_RECOV -> SETUP) | IDLE.
//  SETUP 1 clk: ce_n=0, ab_n/dc_n/d_out/d_oe driven, rd_n=wr_n=1.
//  STROBE STROBE_CYCLES clks: rd_n or wr_n=0; read data captured on last strobe clk.
//  HOLD 1 clk: strobes=1, ce_n=0, d_oe kept; then ce_n=1, d_oe=0.
//  Recovery counter loads RECOVERY_CYCLES on leaving HOLD; new SETUP only at 0.
//  Control reg 0 or data port: one cycle. Control reg 1..15: pointer phase
//   (write 0x0R, dc_n=0) + PTR_RECOV (RECOVERY_CYCLES clks) + data phase (dc_n=0).
//  cpu_ack pulses in the HOLD clk of the final phase. Latency from accept
//   (IDLE clk with req, counter 0): single = STROBE_CYCLES+2 clks to ack;
//   pointered = 2*(STROBE_CYCLES+2)+RECOVERY_CYCLES.
//  Arbitration in IDLE only: pending init > cpu_req. Transfers are never preempted.
//  init_start while idle or during CPU access: latched pending; ignored if busy.
//  Init: init_addr steps 0..INIT_LEN-1; each entry is a write (pointered unless
//   reg=0); entry sampled one clk after init_addr update, before SETUP.
//   init_busy clears in last entry's HOLD; cpu_req served after its recovery.
//  cpu_req is not consumed/acked while init_busy; it waits.
//  cpu_req deasserted before ack: in-flight transfer completes, ack still pulses.
//  Reset mid-transfer: strobes released immediately, no ack, init aborted.
// TESTING
//  Reset: after reset_n low then high, all strobes 1, d_oe 0, ack 0, init_busy 0.
//  CPU write chan A reg 5=0x68: ce/wr see 0x05 dc_n=0, 6 clk gap, 0x68 dc_n=0; ack at clk 18.
//  CPU read data port chan B, scc_d_in=0xA5: ab_n=0 dc_n=1 rd_n low 4 clks; ack clk 6, rdata 0xA5.
//  Back-to-back reg-0 writes: second SETUP exactly 6 clks after first HOLD.
//  init_start with INIT_LEN=3 and cpu_req same clk: 3 table writes first, then CPU; ack after init_busy falls.
//  reset_n low during STROBE of pointered write: rd/wr/ce high same clk, no ack, FSM idle.

Source files
------------

// File: rtl/scc_access_ctl.sv
// Z8530 SCC bus sequencer: turns CPU register requests and a boot init table into
// timed CE_n/RD_n/WR_n cycles, inserting WR0 pointer writes and recovery gaps.
module scc_access_ctl #(
    parameter int unsigned STROBE_CYCLES   = 4,
    parameter int unsigned RECOVERY_CYCLES = 6,
    parameter int unsigned INIT_LEN        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_data,
    input  logic        cpu_chan,
    input  logic [3:0]  cpu_reg,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        init_start,
    output logic        init_busy,
    output logic [7:0]  init_addr,
    input  logic [12:0] init_entry,
    output logic        scc_ce_n,
    output logic        scc_rd_n,
    output logic        scc_wr_n,
    output logic        scc_ab_n,
    output logic        scc_dc_n,
    output logic [7:0]  scc_d_out,
    output logic        scc_d_oe,
    input  logic [7:0]  scc_d_in
);

    localparam int unsigned SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int unsigned RW = $clog2(RECOVERY_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_ADDR,
        S_INIT_LOAD,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_PTR_RECOV
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [SW-1:0] r_scnt;
    logic [RW-1:0] r_recov;
    logic          r_we;
    logic          r_dport;
    logic          r_chan;
    logic [3:0]    r_reg;
    logic [7:0]    r_wdata;
    logic [7:0]    r_rdata;
    logic          r_ptr_phase;
    logic          r_is_init;
    logic          r_init_busy;
    logic          r_init_pend;
    logic [7:0]    r_init_addr;

    logic          w_recov_done;
    logic          w_strobe_last;
    logic          w_init_last;
    logic          w_init_go;
    logic          w_accept_init;
    logic          w_accept_cpu;
    logic          w_write;
    logic [7:0]    w_wbyte;

    logic          w_ce_n;
    logic          w_rd_n;
    logic          w_wr_n;
    logic          w_ab_n;
    logic          w_dc_n;
    logic [7:0]    w_d_out;
    logic          w_d_oe;
    logic          w_ack;

    // Counter reaches zero on the edge into SETUP, so SETUP is allowed when it reads 1 or 0.
    assign w_recov_done  = (r_recov <= RW'(1));
    assign w_strobe_last = (r_scnt == SW'(STROBE_CYCLES - 1));
    assign w_init_last   = (r_init_addr == 8'(INIT_LEN - 1));
    assign w_init_go     = r_init_pend | (init_start & ~r_init_busy);
    assign w_accept_init = (r_state == S_IDLE) & w_recov_done & w_init_go;
    assign w_accept_cpu  = (r_state == S_IDLE) & w_recov_done & ~w_init_go & cpu_req & ~r_init_busy;
    assign w_write       = r_ptr_phase | r_we;
    assign w_wbyte       = r_ptr_phase ? {4'h0, r_reg} : r_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept_init) begin
                    w_next = S_INIT_ADDR;
                end else if (w_accept_cpu) begin
                    w_next = S_SETUP;
                end
            end
            S_INIT_ADDR: w_next = S_INIT_LOAD;
            S_INIT_LOAD: begin
                if (w_recov_done) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP:     w_next = S_STROBE;
            S_STROBE: begin
                if (w_strobe_last) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_ptr_phase) begin
                    w_next = S_PTR_RECOV;
                end else if (r_is_init && !w_init_last) begin
                    w_next = S_INIT_ADDR;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_PTR_RECOV: begin
                if (w_recov_done) begin
                    w_next = S_SETUP;
                end
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ce_n  = 1'b1;
        w_rd_n  = 1'b1;
        w_wr_n  = 1'b1;
        w_ab_n  = 1'b1;
        w_dc_n  = 1'b0;
        w_d_out = '0;
        w_d_oe  = 1'b0;
        w_ack   = 1'b0;
        case (r_state)
            S_SETUP, S_STROBE, S_HOLD: begin
                w_ce_n  = 1'b0;
                w_ab_n  = ~r_chan;
                w_dc_n  = r_dport;
                w_d_out = w_write ? w_wbyte : 8'h00;
                w_d_oe  = w_write;
                if (r_state == S_STROBE) begin
                    w_rd_n = w_write;
                    w_wr_n = ~w_write;
                end
                if (r_state == S_HOLD) begin
                    w_ack = ~r_ptr_phase & ~r_is_init;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scnt      <= '0;
            r_recov     <= '0;
            r_we        <= 1'b0;
            r_dport     <= 1'b0;
            r_chan      <= 1'b0;
            r_reg       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_ptr_phase <= 1'b0;
            r_is_init   <= 1'b0;
            r_init_busy <= 1'b0;
            r_init_pend <= 1'b0;
            r_init_addr <= '0;
        end else begin
            if (r_state == S_STROBE) begin
                r_scnt <= r_scnt + 1'b1;
            end else begin
                r_scnt <= '0;
            end

            if (r_state == S_HOLD) begin
                r_recov <= RW'(RECOVERY_CYCLES);
            end else if (r_recov != '0) begin
                r_recov <= r_recov - 1'b1;
            end

            if (w_accept_init) begin
                r_init_busy <= 1'b1;
                r_init_addr <= '0;
                r_init_pend <= 1'b0;
            end else if (init_start && !r_init_busy) begin
                r_init_pend <= 1'b1;
            end

            if (w_accept_cpu) begin
                r_we        <= cpu_we;
                r_dport     <= cpu_data;
                r_chan      <= cpu_chan;
                r_reg       <= cpu_reg;
                r_wdata     <= cpu_wdata;
                r_is_init   <= 1'b0;
                r_ptr_phase <= ~cpu_data & (cpu_reg != 4'd0);
            end

            // Entry is re-sampled every clock while waiting out recovery; the ROM holds it stable.
            if (r_state == S_INIT_LOAD) begin
                r_we        <= 1'b1;
                r_dport     <= 1'b0;
                r_chan      <= init_entry[12];
                r_reg       <= init_entry[11:8];
                r_wdata     <= init_entry[7:0];
                r_is_init   <= 1'b1;
                r_ptr_phase <= (init_entry[11:8] != 4'd0);
            end

            if (r_state == S_STROBE && w_strobe_last && !w_write) begin
                r_rdata <= scc_d_in;
            end

            if (r_state == S_HOLD) begin
                if (r_ptr_phase) begin
                    r_ptr_phase <= 1'b0;
                end else if (r_is_init) begin
                    if (w_init_last) begin
                        r_init_busy <= 1'b0;
                    end else begin
                        r_init_addr <= r_init_addr + 8'd1;
                    end
                end
            end
        end
    end

    assign scc_ce_n  = w_ce_n;
    assign scc_rd_n  = w_rd_n;
    assign scc_wr_n  = w_wr_n;
    assign scc_ab_n  = w_ab_n;
    assign scc_dc_n  = w_dc_n;
    assign scc_d_out = w_d_out;
    assign scc_d_oe  = w_d_oe;
    assign cpu_ack   = w_ack;
    assign cpu_rdata = r_rdata;
    assign init_busy = r_init_busy;
    assign init_addr = r_init_addr;

endmodule

// File: tb/tb_scc_access_ctl.sv
// Bench for scc_access_ctl: directed CPU/init sequences with scoreboarded SCC bus
// cycles and CPU acks checked by a negedge monitor.
module tb_scc_access_ctl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_data, cpu_chan;
    logic [3:0]  cpu_reg;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic        init_start, init_busy;
    logic [7:0]  init_addr;
    logic [12:0] init_entry;
    logic        scc_ce_n, scc_rd_n, scc_wr_n, scc_ab_n, scc_dc_n, scc_d_oe;
    logic [7:0]  scc_d_out, scc_d_in;

    always #5 clk = ~clk;

    scc_access_ctl #(
        .STROBE_CYCLES  (4),
        .RECOVERY_CYCLES(6),
        .INIT_LEN       (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_data  (cpu_data),
        .cpu_chan  (cpu_chan),
        .cpu_reg   (cpu_reg),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .init_start(init_start),
        .init_busy (init_busy),
        .init_addr (init_addr),
        .init_entry(init_entry),
        .scc_ce_n  (scc_ce_n),
        .scc_rd_n  (scc_rd_n),
        .scc_wr_n  (scc_wr_n),
        .scc_ab_n  (scc_ab_n),
        .scc_dc_n  (scc_dc_n),
        .scc_d_out (scc_d_out),
        .scc_d_oe  (scc_d_oe),
        .scc_d_in  (scc_d_in)
    );

    // Synchronous init ROM: entry appears one clock after its address.
    logic [12:0] rom [0:2];
    initial begin
        rom[0] = {1'b0, 4'd9, 8'hC0};
        rom[1] = {1'b1, 4'd0, 8'h10};
        rom[2] = {1'b0, 4'd4, 8'h44};
    end
    always @(posedge clk) init_entry <= (init_addr < 8'd3) ? rom[init_addr[1:0]] : 13'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       ab_n;
        logic       dc_n;
        logic       wr;
        logic [7:0] data;
        int         gap;
    } bus_t;

    typedef struct {
        int         cyc;
        logic       chk_rd;
        logic [7:0] rdata;
        logic       after_init;
    } ack_t;

    bus_t bus_q[$];
    ack_t ack_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ack_cnt = 0;
    int   setup_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bus(input logic ab_n, input logic dc_n, input logic wr,
                            input logic [7:0] data, input int gap);
        bus_t b;
        b.ab_n = ab_n; b.dc_n = dc_n; b.wr = wr; b.data = data; b.gap = gap;
        bus_q.push_back(b);
    endtask

    task automatic issue(input logic we, input logic dport, input logic chan,
                         input logic [3:0] rg, input logic [7:0] wd, input int lat,
                         input logic chk_rd, input logic [7:0] exp_rd, input logic after_init);
        ack_t a;
        cpu_we = we; cpu_data = dport; cpu_chan = chan; cpu_reg = rg; cpu_wdata = wd;
        cpu_req = 1'b1;
        a.cyc = cyc + lat; a.chk_rd = chk_rd; a.rdata = exp_rd; a.after_init = after_init;
        ack_q.push_back(a);
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ack && n < 200);
        if (!cpu_ack) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no ack required ack within 200 cycles", tag);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_strobes"}, {scc_ce_n, scc_rd_n, scc_wr_n}, 3'b111);
        chk({tag, "_bus"}, {scc_ab_n, scc_dc_n, scc_d_oe, scc_d_out}, {3'b100, 8'h00});
        chk({tag, "_ctl"}, {cpu_ack, init_busy}, 2'b00);
    endtask

    // Monitor: reconstructs each SCC cycle and each CPU ack and checks them against the queues.
    initial begin
        logic       prev_ce_n = 1'b1;
        logic       prev_strb = 1'b0;
        int         scnt = 0;
        int         last_hold = -1000;
        int         cur_gap = 0;
        logic       s_ab = 1'b0, s_dc = 1'b0, s_wr = 1'b0, s_oe = 1'b0;
        logic [7:0] s_data = 8'h00;
        bus_t       e;
        ack_t       a;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_ce_n = 1'b1;
                prev_strb = 1'b0;
                scnt = 0;
            end else begin
                if (!scc_ce_n && prev_ce_n) begin
                    setup_cnt++;
                    cur_gap = cyc - last_hold - 1;
                end
                if (!scc_rd_n || !scc_wr_n) begin
                    scnt++;
                    s_ab = scc_ab_n; s_dc = scc_dc_n; s_wr = !scc_wr_n;
                    s_oe = scc_d_oe; s_data = scc_d_out;
                end else if (!scc_ce_n && prev_strb) begin
                    last_hold = cyc;
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected_cycle", 1, 0);
                    end else begin
                        e = bus_q.pop_front();
                        chk("bus_fields", {s_ab, s_dc, s_wr, s_oe, (s_wr ? s_data : 8'h00)},
                            {e.ab_n, e.dc_n, e.wr, e.wr, (e.wr ? e.data : 8'h00)});
                        chk("strobe_len", scnt, 4);
                        if (e.gap >= 0) chk("recovery_gap", cur_gap, e.gap);
                    end
                    scnt = 0;
                end
                prev_ce_n = scc_ce_n;
                prev_strb = !scc_rd_n || !scc_wr_n;
                if (cpu_ack) begin
                    ack_cnt++;
                    if (ack_q.size() == 0) begin
                        chk("ack_unexpected", 1, 0);
                    end else begin
                        a = ack_q.pop_front();
                        chk("ack_cycle", cyc, a.cyc);
                        if (a.chk_rd) chk("ack_rdata", cpu_rdata, a.rdata);
                        if (a.after_init) chk("ack_after_init", {init_busy, bus_q.size() != 0}, 0);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish required finish within 1 ms");
        $fatal(1);
    end

    initial begin
        int snap_ack, snap_setup, n;
        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_data = 1'b0; cpu_chan = 1'b0;
        cpu_reg = 4'd0; cpu_wdata = 8'h00; init_start = 1'b0; scc_d_in = 8'h00;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset_held");
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("reset_released");
        chk("reset_rdata_addr", {cpu_rdata, init_addr}, 16'h0000);
        repeat (2) @(negedge clk);

        // Pointered control write, chan A reg 5 = 0x68: ack 18 clocks after accept.
        issue(1'b1, 1'b0, 1'b0, 4'd5, 8'h68, 18, 1'b0, 8'h00, 1'b0);
        push_bus(1'b1, 1'b0, 1'b1, 8'h05, -1);
        push_bus(1'b1, 1'b0, 1'b1, 8'h68, 6);
        wait_ack("ptr_write");
        cpu_req = 1'b0;
        repeat (10) @(negedge clk);

        // Data-port read, chan B.
        scc_d_in = 8'hA5;
        issue(1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 6, 1'b1, 8'hA5, 1'b0);
        push_bus(1'b0, 1'b1, 1'b0, 8'h00, -1);
        wait_ack("data_read");
        cpu_req = 1'b0;
        repeat (10) @(negedge clk);

        // Pointered control read, chan B reg 3.
        scc_d_in = 8'h5A;
        issue(1'b0, 1'b0, 1'b1, 4'd3, 8'h00, 18, 1'b1, 8'h5A, 1'b0);
        push_bus(1'b0, 1'b0, 1'b1, 8'h03, -1);
        push_bus(1'b0, 1'b0, 1'b0, 8'h00, 6);
        wait_ack("ptr_read");
        cpu_req = 1'b0;
        scc_d_in = 8'h00;
        repeat (10) @(negedge clk);

        // Back-to-back reg-0 writes: second request presented in the first ack clock.
        issue(1'b1, 1'b0, 1'b0, 4'd0, 8'h11, 6, 1'b0, 8'h00, 1'b0);
        push_bus(1'b1, 1'b0, 1'b1, 8'h11, -1);
        wait_ack("b2b_first");
        issue(1'b1, 1'b0, 1'b1, 4'd0, 8'h22, 12, 1'b0, 8'h00, 1'b0);
        push_bus(1'b0, 1'b0, 1'b1, 8'h22, 6);
        wait_ack("b2b_second");
        cpu_req = 1'b0;
        chk("rdata_held", cpu_rdata, 8'h5A);
        repeat (10) @(negedge clk);

        // Request dropped right after accept: transfer and ack still complete.
        issue(1'b1, 1'b1, 1'b0, 4'd0, 8'h77, 6, 1'b0, 8'h00, 1'b0);
        push_bus(1'b1, 1'b1, 1'b1, 8'h77, -1);
        @(negedge clk);
        cpu_req = 1'b0;
        wait_ack("early_drop");
        repeat (10) @(negedge clk);

        // Init table (3 entries) and a CPU write raised in the same clock; init goes first.
        init_start = 1'b1;
        issue(1'b1, 1'b0, 1'b1, 4'd0, 8'h3C, 68, 1'b0, 8'h00, 1'b1);
        push_bus(1'b1, 1'b0, 1'b1, 8'h09, -1);
        push_bus(1'b1, 1'b0, 1'b1, 8'hC0, 6);
        push_bus(1'b0, 1'b0, 1'b1, 8'h10, 6);
        push_bus(1'b1, 1'b0, 1'b1, 8'h04, 6);
        push_bus(1'b1, 1'b0, 1'b1, 8'h44, 6);
        push_bus(1'b0, 1'b0, 1'b1, 8'h3C, 6);
        @(negedge clk);
        init_start = 1'b0;
        chk("init_busy_rise", init_busy, 1);
        wait_ack("init_then_cpu");
        cpu_req = 1'b0;
        repeat (10) @(negedge clk);

        // Reset during the pointer-phase strobe of a pointered write.
        cpu_we = 1'b1; cpu_data = 1'b0; cpu_chan = 1'b0; cpu_reg = 4'd7; cpu_wdata = 8'h12;
        cpu_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (scc_wr_n && n < 20);
        chk("abort_strobe_seen", scc_wr_n, 0);
        snap_ack = ack_cnt;
        snap_setup = setup_cnt;
        #2;
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("abort_strobes_released", {scc_ce_n, scc_rd_n, scc_wr_n, scc_d_oe}, 4'b1110);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_ack", ack_cnt, snap_ack);
        chk("abort_fsm_idle", setup_cnt, snap_setup);
        chk_idle_outputs("abort_after");

        repeat (5) @(negedge clk);
        chk("bus_queue_left", bus_q.size(), 0);
        chk("ack_queue_left", ack_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
